bus_oe_arbiter: RTL and testbench

- Round-robin arbiter sharing one 8-bit tristate data bus among N bus drivers, such as counters and registers that each have an `oe` input.
- Issues a registered one-hot output-enable so that at most one driver is on the bus in any cycle.
- Inserts a one-cycle turnaround between owners so no two drivers overlap.
- Optional hold-time limit forces rotation when a driver holds the bus too long.

---
 rtl/bus_oe_arbiter_if.sv | 28 ++
 rtl/bus_oe_arbiter.sv | 116 +++++++++++
 tb/tb_bus_oe_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_oe_arbiter_if.sv
// Shared tristate-bus handshake: per-driver requests in, one-hot output enables out.
// The arbiter takes the master modport; the bus drivers take slave.
interface bus_oe_arbiter_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic [N-1:0]     req;
    logic [N-1:0]     oe;
    logic             bus_busy;
    logic [IDX_W-1:0] owner;
    logic             preempt;

    modport master (
        input  req,
        output oe,
        output bus_busy,
        output owner,
        output preempt
    );

    modport slave (
        output req,
        input  oe,
        input  bus_busy,
        input  owner,
        input  preempt
    );
endinterface

// File: rtl/bus_oe_arbiter.sv
// Round-robin owner of a shared 8-bit tristate bus with a one-cycle turnaround.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD grant cycles.
module bus_oe_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    bus_oe_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    localparam logic P_OK = (N >= 2) && (N <= 8) && (IDX_W >= $clog2(N))
                         && (MAX_HOLD >= 2) && (MAX_HOLD <= 255);

    state_t           r_state;
    logic [N-1:0]     r_oe;
    logic             r_busy;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last;
    logic             r_preempt;

    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic             w_own;
    logic             w_tmo;

    // Scan downward so the nearest index after r_last wins the final write.
    function automatic logic [IDX_W-1:0] f_pick(
        input logic [N-1:0]     r,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W-1:0] w;
        logic [N-1:0]     t;
        int               j;
        w = last;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last) + k) % N;
            t = r >> j;
            if (t[0]) w = IDX_W'(j);
        end
        return w;
    endfunction

    assign w_win = f_pick(bus.req, r_last);
    assign w_any = |bus.req;
    assign w_own = |(bus.req & r_oe);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    assign w_tmo = (r_state == S_GRANT) && (r_hold == 8'(MAX_HOLD))
                && |(bus.req & ~r_oe);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_oe      <= '0;
            r_busy    <= 1'b0;
            r_owner   <= '0;
            r_last    <= IDX_W'(N - 1);
            r_preempt <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_hold    <= 8'd0;
`endif
        end else begin
            r_preempt <= 1'b0;
            unique case (r_state)
                S_GRANT: begin
                    if (w_tmo || !w_own) begin
                        r_state   <= S_TURN;
                        r_oe      <= '0;
                        r_busy    <= 1'b0;
                        r_preempt <= w_tmo;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_hold != 8'(MAX_HOLD)) begin
                        r_hold <= r_hold + 8'd1;
                    end
`endif
                end
                default: begin
                    // IDLE and the end of TURN arbitrate identically.
                    if (w_any) begin
                        r_state <= S_GRANT;
                        r_oe    <= {{(N-1){1'b0}}, 1'b1} << w_win;
                        r_busy  <= 1'b1;
                        r_owner <= w_win;
                        r_last  <= w_win;
`ifdef ARB_TIMEOUT_EN
                        r_hold  <= 8'd1;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.oe       = r_oe;
    assign bus.bus_busy = r_busy;
    assign bus.owner    = r_owner;
    assign bus.preempt  = r_preempt;

    a_onehot: assert property (
        @(posedge clk) P_OK && ($countones(r_oe) <= 1)
    );
endmodule

// File: tb/tb_bus_oe_arbiter.sv
// Directed and random checks of bus_oe_arbiter against a cycle-level ownership model.
module tb_bus_oe_arbiter;
    localparam int N = 4;
    localparam int IDX_W = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int MAXH = 4;
`else
    localparam int MAXH = 16;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_oe_arbiter_if #(.N(N), .IDX_W(IDX_W)) bif();

    bus_oe_arbiter #(
        .N(N),
        .IDX_W(IDX_W),
        .MAX_HOLD(MAXH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who holds the bus (-1 none), last winner, grant length.
    int m_cur = -1;
    int m_owner = 0;
    int m_last = N - 1;
    int m_hold = 0;
    bit m_pre = 1'b0;

    always @(posedge clk or posedge reset) begin
        int j;
        if (reset) begin
            m_cur = -1;
            m_owner = 0;
            m_last = N - 1;
            m_hold = 0;
            m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_cur < 0) begin
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (bif.req[j] && m_cur < 0) begin
                        m_cur = j;
                        m_owner = j;
                        m_last = j;
                        m_hold = 1;
                    end
                end
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_hold == MAXH
                     && (int'(bif.req) & ~(1 << m_cur)) != 0) begin
                m_cur = -1;
                m_pre = 1'b1;
            end
`endif
            else if (!bif.req[m_cur]) begin
                m_cur = -1;
            end else if (m_hold < MAXH) begin
                m_hold++;
            end
        end
    end

    logic [N-1:0] prev_oe = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_oe = '0;
        end else begin
            chk("model_oe", 32'(bif.oe), m_cur < 0 ? 32'd0 : 32'(1 << m_cur));
            chk("model_busy", 32'(bif.bus_busy), 32'(m_cur >= 0));
            chk("model_owner", 32'(bif.owner), 32'(m_owner));
            chk("model_preempt", 32'(bif.preempt), 32'(m_pre));
            chk("onehot", 32'($countones(bif.oe) <= 1), 32'd1);
            chk("turnaround",
                32'(prev_oe != 0 && bif.oe != 0 && prev_oe != bif.oe), 32'd0);
            prev_oe = bif.oe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bif.req = '0;
        #1 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    int seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.req = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_oe", 32'(bif.oe), 32'd0);
        chk("rst_busy", 32'(bif.bus_busy), 32'd0);
        chk("rst_owner", 32'(bif.owner), 32'd0);
        chk("rst_preempt", 32'(bif.preempt), 32'd0);
        reset = 1'b0;

        // Single requester: one-cycle latency, drop returns to idle.
        bif.req = 4'b0001;
        tick();
        chk("t1_oe", 32'(bif.oe), 32'b0001);
        chk("t1_owner", 32'(bif.owner), 32'd0);
        chk("t1_busy", 32'(bif.bus_busy), 32'd1);
        bif.req = 4'b0000;
        tick();
        chk("t1_drop_oe", 32'(bif.oe), 32'd0);
        chk("t1_drop_busy", 32'(bif.bus_busy), 32'd0);
        tick();
        chk("t1_idle_oe", 32'(bif.oe), 32'd0);
        chk("t1_idle_owner", 32'(bif.owner), 32'd0);

        // Round robin with all requesting.
        do_reset();
        bif.req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rr_oe", 32'(bif.oe), 32'(1 << seq[i]));
            chk("rr_owner", 32'(bif.owner), 32'(seq[i]));
            tick();
            tick();
            chk("rr_hold", 32'(bif.oe), 32'(1 << seq[i]));
            bif.req = 4'(4'b1111 & ~(1 << seq[i]));
            tick();
            chk("rr_gap", 32'(bif.oe), 32'd0);
            bif.req = 4'b1111;
            tick();
        end

        // Wrap past last=2 to index 0, then skip to 1.
        do_reset();
        bif.req = 4'b0100;
        tick();
        chk("wrap_own2", 32'(bif.oe), 32'b0100);
        bif.req = 4'b0000;
        tick();
        bif.req = 4'b0011;
        tick();
        chk("wrap_oe0", 32'(bif.oe), 32'b0001);
        chk("wrap_owner0", 32'(bif.owner), 32'd0);
        bif.req = 4'b0010;
        tick();
        chk("skip_gap", 32'(bif.oe), 32'd0);
        tick();
        chk("skip_oe1", 32'(bif.oe), 32'b0010);

        // Async reset mid-grant clears oe before any edge.
        do_reset();
        bif.req = 4'b0100;
        tick();
        tick();
        chk("ar_pre_oe", 32'(bif.oe), 32'b0100);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("ar_oe", 32'(bif.oe), 32'd0);
        chk("ar_busy", 32'(bif.bus_busy), 32'd0);
        chk("ar_owner", 32'(bif.owner), 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("ar_regrant", 32'(bif.oe), 32'b0100);
        chk("ar_owner2", 32'(bif.owner), 32'd2);
        bif.req = 4'b0000;
        tick();
        do_reset();
        bif.req = 4'b1001;
        tick();
        chk("ar_last3", 32'(bif.owner), 32'd0);
        bif.req = 4'b0000;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Hold-time limit forces rotation to the waiting requester.
        do_reset();
        bif.req = 4'b0010;
        tick();
        chk("to_g1", 32'(bif.oe), 32'b0010);
        tick();
        bif.req = 4'b1010;
        tick();
        tick();
        chk("to_g4", 32'(bif.oe), 32'b0010);
        tick();
        chk("to_turn", 32'(bif.oe), 32'd0);
        chk("to_pre", 32'(bif.preempt), 32'd1);
        tick();
        chk("to_oe3", 32'(bif.oe), 32'b1000);
        chk("to_pre_off", 32'(bif.preempt), 32'd0);
        bif.req = 4'b0000;
        tick();
`endif

        // Random traffic, checked every cycle by the model.
        do_reset();
        repeat (10000) begin
            bif.req = bif.req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            tick();
        end
        bif.req = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
